// File: rtl/pocket_lab_pkg.sv
// rtl/pocket_lab_pkg.sv - shared constants and parser state type for the pocket lab core
package pocket_lab_pkg;

   localparam logic [7:0] SYNC_BYTE  = 8'h5A;

   localparam logic [7:0] OP_WRITE   = 8'h01;
   localparam logic [7:0] OP_READ    = 8'h02;
   localparam logic [7:0] OP_CAPTURE = 8'h10;
   localparam logic [7:0] OP_DUMP    = 8'h11;

   localparam logic [7:0] REG_DIV    = 8'h00;
   localparam logic [7:0] REG_DAC    = 8'h01;
   localparam logic [7:0] REG_TRIG   = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPC,
      ST_WADDR,
      ST_WDATA,
      ST_RADDR,
      ST_DUMP
   } parser_state_t;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ) || (b == OP_CAPTURE) || (b == OP_DUMP);
   endfunction

endpackage

// File: rtl/pocket_lab_core_if.sv
// rtl/pocket_lab_core_if.sv - SPI bus between host (master) and pocket lab core (slave)
interface pocket_lab_core_if;
   logic spi_clk;
   logic spi_mosi;
   logic spi_miso;
   logic spi_cs;

   modport master (output spi_clk, output spi_mosi, output spi_cs, input spi_miso);
   modport slave  (input spi_clk, input spi_mosi, input spi_cs, output spi_miso);
endinterface

// File: rtl/pocket_lab_core_spi_slave_byte.sv
// rtl/pocket_lab_core_spi_slave_byte.sv - mode-3 SPI byte engine: input sync, edge detect, shift in/out
module spi_slave_byte #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk_i,
   input  logic       spi_mosi_i,
   input  logic       spi_cs_i,
   output logic       spi_miso_o,
   input  logic [7:0] tx_byte_i,
   output logic [7:0] rx_byte_o,
   output logic       byte_done_o,
   output logic       cs_sync_o
);
   logic [SYNC_STAGES-1:0] clk_sync_q, mosi_sync_q, cs_sync_q;
   logic       sclk_s, mosi_s, cs_s;
   logic       clk_prev_q;
   logic       rise, fall;
   logic [2:0] bit_cnt_q;
   logic [6:0] rx_shift_q;
   logic [7:0] rx_byte_q;
   logic [7:0] tx_shift_q;
   logic       byte_done_q;
   logic       load_q;

   assign sclk_s = clk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign rise   = sclk_s & ~clk_prev_q;
   assign fall   = ~sclk_s & clk_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '1;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         clk_prev_q  <= 1'b1;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 7'd0;
         rx_byte_q   <= 8'd0;
         tx_shift_q  <= 8'd0;
         byte_done_q <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
         clk_prev_q  <= sclk_s;
         byte_done_q <= 1'b0;
         load_q      <= byte_done_q;
         if (!cs_s) begin
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 8'd0;
         end else begin
            if (rise) begin
               rx_shift_q <= {rx_shift_q[5:0], mosi_s};
               bit_cnt_q  <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_done_q <= 1'b1;
                  rx_byte_q   <= {rx_shift_q, mosi_s};
               end
            end
            // The leading fall of each byte must not shift: bit7 has to survive until the first rise.
            if (load_q)
               tx_shift_q <= tx_byte_i;
            else if (fall && bit_cnt_q != 3'd0)
               tx_shift_q <= {tx_shift_q[6:0], 1'b0};
         end
      end
   end

   assign spi_miso_o  = cs_s & tx_shift_q[7];
   assign rx_byte_o   = rx_byte_q;
   assign byte_done_o = byte_done_q;
   assign cs_sync_o   = cs_s;
endmodule

// File: rtl/pocket_lab_core.sv
// rtl/pocket_lab_core.sv - pocket lab top: clock divider, ADC capture buffer, DAC register, SPI command parser
// Build option POCKET_LAB_TRIG_DEBUG_EN routes internal strobes to triggers instead of the TRIG register.
module pocket_lab_core
   import pocket_lab_pkg::*;
#(
   parameter int BUF_DEPTH   = 16,
   parameter int TRIG_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              osc_27m,
   input  logic              rst_key,
   output logic              adc_clk,
   input  logic [7:0]        adc_data,
   output logic              dac_clk,
   output logic [7:0]        dac_data,
   pocket_lab_core_if.slave  spi,
   output logic [TRIG_W-1:0] triggers
);
   localparam int IDX_W = $clog2(BUF_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);

   logic [7:0] div_q, dac_q, trig_q;
   logic [7:0] div_cnt_q, div_act_q;
   logic       adc_clk_q;
   logic [7:0] dac_data_q;
   logic       toggle, sample_stb, dac_stb;

   logic [7:0] rx_byte;
   logic       byte_done, cs_sync;
   logic [7:0] tx_byte_q;
   logic [7:0] rd_val;

   parser_state_t    state_q;
   logic [7:0]       addr_q;
   logic [IDX_W-1:0] dump_idx_q, dump_nxt, cap_idx_q;
   logic             busy_q;
   logic [7:0]       cap_mem_q [BUF_DEPTH];

   spi_slave_byte #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
      .clk         (osc_27m),
      .rst         (rst_key),
      .spi_clk_i   (spi.spi_clk),
      .spi_mosi_i  (spi.spi_mosi),
      .spi_cs_i    (spi.spi_cs),
      .spi_miso_o  (spi.spi_miso),
      .tx_byte_i   (tx_byte_q),
      .rx_byte_o   (rx_byte),
      .byte_done_o (byte_done),
      .cs_sync_o   (cs_sync)
   );

   // div_act_q snapshots DIV at each toggle so a mid-half-period write never shortens the current half.
   assign toggle     = (div_cnt_q == div_act_q);
   assign sample_stb = toggle & adc_clk_q;
   assign dac_stb    = toggle & ~adc_clk_q;

   always_ff @(posedge osc_27m) begin
      if (rst_key) begin
         adc_clk_q  <= 1'b0;
         div_cnt_q  <= 8'd0;
         div_act_q  <= 8'd0;
         dac_data_q <= 8'd0;
      end else begin
         if (toggle) begin
            adc_clk_q <= ~adc_clk_q;
            div_cnt_q <= 8'd0;
            div_act_q <= div_q;
         end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
         end
         if (dac_stb)
            dac_data_q <= dac_q;
      end
   end

   always_ff @(posedge osc_27m) begin
      if (!rst_key && busy_q && sample_stb)
         cap_mem_q[cap_idx_q] <= adc_data;
   end

   always_comb begin
      rd_val = 8'h00;
      case (rx_byte)
         REG_DIV:  rd_val = div_q;
         REG_DAC:  rd_val = dac_q;
         REG_TRIG: rd_val = trig_q;
         default:  rd_val = 8'h00;
      endcase
   end

   assign dump_nxt = dump_idx_q + IDX_W'(1);

`ifdef POCKET_LAB_TRIG_DEBUG_EN
   logic frame_ok_q;
`endif

   always_ff @(posedge osc_27m) begin
      if (rst_key) begin
         state_q    <= ST_IDLE;
         addr_q     <= 8'd0;
         tx_byte_q  <= 8'd0;
         dump_idx_q <= '0;
         cap_idx_q  <= '0;
         busy_q     <= 1'b0;
         div_q      <= 8'd0;
         dac_q      <= 8'd0;
         trig_q     <= 8'd0;
`ifdef POCKET_LAB_TRIG_DEBUG_EN
         frame_ok_q <= 1'b0;
`endif
      end else begin
`ifdef POCKET_LAB_TRIG_DEBUG_EN
         frame_ok_q <= 1'b0;
`endif
         if (busy_q && sample_stb) begin
            cap_idx_q <= cap_idx_q + IDX_W'(1);
            if (cap_idx_q == LAST_IDX)
               busy_q <= 1'b0;
         end
         if (!cs_sync) begin
            state_q   <= ST_IDLE;
            tx_byte_q <= 8'h00;
         end else if (byte_done) begin
            tx_byte_q <= 8'h00;
            case (state_q)
               ST_IDLE: if (rx_byte == SYNC_BYTE) state_q <= ST_OPC;
               ST_OPC: begin
                  state_q <= ST_IDLE;
`ifdef POCKET_LAB_TRIG_DEBUG_EN
                  frame_ok_q <= is_opcode(rx_byte);
`endif
                  case (rx_byte)
                     OP_WRITE: state_q <= ST_WADDR;
                     OP_READ:  state_q <= ST_RADDR;
                     OP_CAPTURE: if (!busy_q) begin
                        busy_q    <= 1'b1;
                        cap_idx_q <= '0;
                     end
                     OP_DUMP: begin
                        state_q    <= ST_DUMP;
                        dump_idx_q <= '0;
                        tx_byte_q  <= cap_mem_q[0];
                     end
                     default: state_q <= ST_IDLE;
                  endcase
               end
               ST_WADDR: begin
                  addr_q  <= rx_byte;
                  state_q <= ST_WDATA;
               end
               ST_WDATA: begin
                  case (addr_q)
                     REG_DIV:  div_q  <= rx_byte;
                     REG_DAC:  dac_q  <= rx_byte;
                     REG_TRIG: trig_q <= rx_byte;
                     default:  ;
                  endcase
                  state_q <= ST_IDLE;
               end
               ST_RADDR: begin
                  tx_byte_q <= rd_val;
                  state_q   <= ST_IDLE;
               end
               ST_DUMP: begin
                  if (dump_idx_q == LAST_IDX) begin
                     state_q <= ST_IDLE;
                  end else begin
                     dump_idx_q <= dump_nxt;
                     tx_byte_q  <= cap_mem_q[dump_nxt];
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign adc_clk  = adc_clk_q;
   assign dac_clk  = ~adc_clk_q;
   assign dac_data = dac_data_q;

`ifdef POCKET_LAB_TRIG_DEBUG_EN
   assign triggers = TRIG_W'({busy_q, frame_ok_q, byte_done, cs_sync});
`else
   assign triggers = TRIG_W'(trig_q);
`endif
endmodule

// File: tb/tb_pocket_lab_core.sv
// tb/tb_pocket_lab_core.sv - self-checking bench for pocket_lab_core: register frames, divider, capture/dump, reset abort
module tb_pocket_lab_core;
   localparam int HALF = 6;

   logic       osc_27m  = 1'b0;
   logic       rst_key  = 1'b1;
   logic [7:0] adc_data = 8'h00;
   logic       adc_clk, dac_clk;
   logic [7:0] dac_data;
   logic [3:0] triggers;

   pocket_lab_core_if spi_bus();

   int total = 0;
   int bad   = 0;

   logic [7:0] tx_buf [32];
   logic [7:0] rx_buf [32];
   logic [7:0] sb_q [$];
   logic [7:0] log_v [$];
   time        log_t [$];
   bit         log_en = 1'b0;
   time        last_rise_t = 0;

   typedef struct {
      logic [63:0] bytes;
      int          n;
      bit          rd;
      logic [7:0]  exp;
   } vec_t;
   vec_t vecs [10];

   always #5 osc_27m = ~osc_27m;

   // Counting ADC: value advances just after each adc_clk rise.
   always @(posedge adc_clk) begin
      #1;
      adc_data = adc_data + 8'd1;
   end

   always @(negedge adc_clk) begin
      if (log_en) begin
         log_v.push_back(adc_data);
         log_t.push_back($time);
      end
   end

   pocket_lab_core dut (
      .osc_27m  (osc_27m),
      .rst_key  (rst_key),
      .adc_clk  (adc_clk),
      .adc_data (adc_data),
      .dac_clk  (dac_clk),
      .dac_data (dac_data),
      .spi      (spi_bus),
      .triggers (triggers)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_compare(input string name, input logic [7:0] act);
      logic [7:0] e;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL %s: got %02h with nothing expected", name, act);
      end else begin
         e = sb_q.pop_front();
         if (act !== e) begin
            bad++;
            $display("FAIL %s: got %02h, expected %02h", name, act, e);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge osc_27m);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      @(negedge osc_27m);
      spi_bus.spi_clk  = 1'b0;
      spi_bus.spi_mosi = b;
      tick(HALF);
      r = spi_bus.spi_miso;
      spi_bus.spi_clk = 1'b1;
      last_rise_t = $time;
      tick(HALF);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   task automatic frame(input int n);
      logic [7:0] r;
      @(negedge osc_27m);
      spi_bus.spi_cs = 1'b1;
      tick(4);
      for (int i = 0; i < n; i++) begin
         spi_byte(tx_buf[i], r);
         rx_buf[i] = r;
      end
      tick(8);
      spi_bus.spi_cs = 1'b0;
      tick(6);
   endtask

   task automatic set4(input logic [31:0] w);
      for (int i = 0; i < 4; i++) tx_buf[i] = w[31-8*i -: 8];
   endtask

   task automatic measure_half(output int n);
      logic prev;
      bit   seen;
      n    = -1;
      seen = 1'b0;
      prev = adc_clk;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge osc_27m);
         if (adc_clk !== prev) seen = 1'b1;
      end
      prev = adc_clk;
      for (int c = 1; c <= 100 && seen && n < 0; c++) begin
         @(negedge osc_27m);
         if (adc_clk !== prev) n = c;
      end
   endtask

   initial begin
      int   n, errs, f, s;
      time  cap_t;
      logic r;
      logic [7:0] dummy;

      spi_bus.spi_clk  = 1'b1;
      spi_bus.spi_mosi = 1'b0;
      spi_bus.spi_cs   = 1'b0;

      rst_key = 1'b1;
      tick(3);
      check("rst_adc_clk", adc_clk, 1'b0);
      check("rst_dac_clk", dac_clk, 1'b1);
      check("rst_dac_data", dac_data, 8'h00);
      check("rst_miso", spi_bus.spi_miso, 1'b0);
      check("rst_triggers", triggers, 4'h0);
      rst_key = 1'b0;

      measure_half(n);
      check("half_period_div0", n, 1);
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge osc_27m);
         if (dac_clk !== ~adc_clk) errs++;
      end
      check("dac_clk_inverse", errs, 0);

      vecs[0] = '{64'h5A0101A5_00000000, 4, 1'b0, 8'h00};
      vecs[1] = '{64'h5A020100_00000000, 4, 1'b1, 8'hA5};
      vecs[2] = '{64'h00FF115A_02010000, 7, 1'b1, 8'hA5};
      vecs[3] = '{64'h5A775A02_01000000, 6, 1'b1, 8'hA5};
      vecs[4] = '{64'h5A01020C_00000000, 4, 1'b0, 8'h00};
      vecs[5] = '{64'h5A020200_00000000, 4, 1'b1, 8'h0C};
      vecs[6] = '{64'h5A020900_00000000, 4, 1'b1, 8'h00};
      vecs[7] = '{64'h5A010755_00000000, 4, 1'b0, 8'h00};
      vecs[8] = '{64'h5A020000_00000000, 4, 1'b1, 8'h00};
      vecs[9] = '{64'h5A020100_00000000, 4, 1'b1, 8'hA5};

      for (int v = 0; v < 10; v++) begin
         for (int i = 0; i < vecs[v].n; i++) tx_buf[i] = vecs[v].bytes[63-8*i -: 8];
         if (vecs[v].rd) sb_q.push_back(vecs[v].exp);
         frame(vecs[v].n);
         if (vecs[v].rd) sb_compare($sformatf("vec%0d_read", v), rx_buf[vecs[v].n-1]);
      end
      tick(10);
      check("dac_data_a5", dac_data, 8'hA5);
      check("triggers_trig_reg", triggers, 4'hC);

      set4(32'h5A010003);
      frame(4);
      tick(20);
      measure_half(n);
      check("half_period_div3", n, 4);
      set4(32'h5A020000);
      sb_q.push_back(8'h03);
      frame(4);
      sb_compare("read_div", rx_buf[3]);

      log_en = 1'b1;
      tx_buf[0] = 8'h5A;
      tx_buf[1] = 8'h10;
      frame(2);
      cap_t = last_rise_t;
      tick(400);
      log_en = 1'b0;

      tx_buf[0] = 8'h5A;
      tx_buf[1] = 8'h11;
      for (int i = 2; i < 18; i++) tx_buf[i] = 8'h00;
      frame(18);

      f = 0;
      while (f < log_t.size() && log_t[f] < cap_t) f++;
      s = -1;
      for (int k = 0; k < 3 && s < 0; k++)
         if (f + k + 15 < log_v.size() && log_v[f+k] === rx_buf[2]) s = f + k;
      check("dump_start_in_window", (s >= 0), 1'b1);
      if (s < 0) s = f;
      for (int i = 0; i < 16; i++)
         sb_q.push_back((s + i < log_v.size()) ? log_v[s+i] : 8'hxx);
      for (int i = 0; i < 16; i++)
         sb_compare($sformatf("dump_%0d", i), rx_buf[2+i]);

      @(negedge osc_27m);
      spi_bus.spi_cs = 1'b1;
      tick(4);
      spi_byte(8'h5A, dummy);
      spi_byte(8'h01, dummy);
      spi_byte(8'h01, dummy);
      for (int i = 7; i >= 4; i--) spi_bit(dummy[0] | 1'b1, r);
      @(negedge osc_27m);
      rst_key = 1'b1;
      @(negedge osc_27m);
      rst_key = 1'b0;
      check("midframe_rst_dac_data", dac_data, 8'h00);
      check("midframe_rst_triggers", triggers, 4'h0);
      for (int i = 3; i >= 0; i--) spi_bit(1'b0, r);
      tick(8);
      spi_bus.spi_cs = 1'b0;
      tick(6);

      set4(32'h5A020100);
      sb_q.push_back(8'h00);
      frame(4);
      sb_compare("post_rst_dac_reg", rx_buf[3]);
      set4(32'h5A01013C);
      frame(4);
      set4(32'h5A020100);
      sb_q.push_back(8'h3C);
      frame(4);
      sb_compare("post_rst_write_read", rx_buf[3]);
      tick(10);
      check("post_rst_dac_data", dac_data, 8'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
